// File: rtl/life_pkg.sv
// Shared types and defaults for the Life simulation core and the display path.
package life_pkg;

    localparam int GRID_W_DEFAULT  = 4;
    localparam int GRID_H_DEFAULT  = 4;
    localparam int CELL_PX_DEFAULT = 4;

    localparam logic [2:0] COLOUR_ALIVE = 3'b111;
    localparam logic [2:0] COLOUR_DEAD  = 3'b000;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        PAINT = 2'd2
    } plot_state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       alive;
    } cell_update_t;

endpackage

// File: rtl/cell_plotter_fifo.sv
// Synchronous FIFO of cell updates; the head entry is presented combinationally.
module cell_fifo
    import life_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  cell_update_t             din,
    output cell_update_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cell_fifo DEPTH must be a power of two, at least 2");
    end

    cell_update_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cell_plotter.sv
// Turns queued cell updates into CELL_PX x CELL_PX pixel writes for the 160x120 vga_adapter,
// and repaints the whole grid area dead after reset or on clear_req.
module cell_plotter
    import life_pkg::*;
#(
    parameter int         GRID_W       = GRID_W_DEFAULT,
    parameter int         GRID_H       = GRID_H_DEFAULT,
    parameter int         CELL_PX      = CELL_PX_DEFAULT,
    parameter int         ORIGIN_X     = 0,
    parameter int         ORIGIN_Y     = 0,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [2:0] ALIVE_COLOUR = COLOUR_ALIVE,
    parameter logic [2:0] DEAD_COLOUR  = COLOUR_DEAD
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_cell_x,
    input  logic [7:0] in_cell_y,
    input  logic       in_alive,
    input  logic       clear_req,
    output logic       busy,
    output logic       dropped,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam int         SH        = $clog2(CELL_PX);
    localparam int         CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] ORG_X     = 8'(ORIGIN_X);
    localparam logic [7:0] ORG_Y     = 8'(ORIGIN_Y);
    localparam logic [7:0] AREA_W_M1 = 8'(GRID_W * CELL_PX - 1);
    localparam logic [7:0] AREA_H_M1 = 8'(GRID_H * CELL_PX - 1);
    localparam logic [7:0] CELL_M1   = 8'(CELL_PX - 1);

    if (CELL_PX < 1 || CELL_PX > 8 || (CELL_PX & (CELL_PX - 1)) != 0) begin : g_bad_cell
        $error("CELL_PX must be a power of two in 1..8");
    end
    if (ORIGIN_X + GRID_W * CELL_PX > 160 || ORIGIN_Y + GRID_H * CELL_PX > 120) begin : g_bad_area
        $error("grid area does not fit inside the 160x120 frame");
    end

    plot_state_t  state;
    cell_update_t head;
    logic [CNT_W-1:0] count;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         clear_pend;
    logic         in_range;
    logic [7:0]   px;
    logic [7:0]   py;
    logic [7:0]   lim_x;
    logic [7:0]   lim_y;
    logic [7:0]   base_x;
    logic [7:0]   base_y;
    logic [2:0]   paint_colour;

    assign in_ready = ~full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !clear_pend && !empty;
    assign busy     = (state != IDLE) || (count != '0);
    assign in_range = (head.x < 8'(GRID_W)) && (head.y < 8'(GRID_H));
    assign lim_x    = (state == CLEAR) ? AREA_W_M1 : CELL_M1;
    assign lim_y    = (state == CLEAR) ? AREA_H_M1 : CELL_M1;

    cell_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     ({in_cell_x, in_cell_y, in_alive}),
        .dout    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= CLEAR;
            px           <= '0;
            py           <= '0;
            base_x       <= ORG_X;
            base_y       <= ORG_Y;
            paint_colour <= DEAD_COLOUR;
            clear_pend   <= 1'b0;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            plot         <= 1'b0;
            dropped      <= 1'b0;
        end else begin
            plot    <= 1'b0;
            dropped <= 1'b0;
            if (clear_req && state != CLEAR) clear_pend <= 1'b1;

            case (state)
                // CLEAR and PAINT share the sweep; only the base, extent and colour differ.
                CLEAR, PAINT: begin
                    plot   <= 1'b1;
                    x      <= base_x + px;
                    y      <= 7'(base_y + py);
                    colour <= paint_colour;
                    if (px == lim_x) begin
                        px <= '0;
                        if (py == lim_y) begin
                            py    <= '0;
                            state <= IDLE;
                        end else begin
                            py <= py + 1'b1;
                        end
                    end else begin
                        px <= px + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_pend) begin
                        clear_pend   <= 1'b0;
                        state        <= CLEAR;
                        base_x       <= ORG_X;
                        base_y       <= ORG_Y;
                        paint_colour <= DEAD_COLOUR;
                    end else if (!empty) begin
                        if (in_range) begin
                            state        <= PAINT;
                            base_x       <= ORG_X + (head.x << SH);
                            base_y       <= ORG_Y + (head.y << SH);
                            paint_colour <= head.alive ? ALIVE_COLOUR : DEAD_COLOUR;
                        end else begin
                            dropped <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_plotter.sv
// Directed bench for cell_plotter with default parameters (4x4 grid, 4-pixel cells).
module tb_cell_plotter;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         t;
    } pix_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_cell_x = '0;
    logic [7:0] in_cell_y = '0;
    logic       in_alive = 1'b0;
    logic       clear_req = 1'b0;
    logic       busy;
    logic       dropped;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   drop_cnt = 0;
    pix_t q[$];

    cell_plotter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cell_x (in_cell_x),
        .in_cell_y (in_cell_y),
        .in_alive  (in_alive),
        .clear_req (clear_req),
        .busy      (busy),
        .dropped   (dropped),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (plot === 1'b1) q.push_back('{x: x, y: y, c: colour, t: cyc});
        if (dropped === 1'b1) drop_cnt <= drop_cnt + 1;
    end

    // Mismatches in one cell_px x cell_px block starting at queue index base.
    function automatic int cell_bad(int base, int cx, int cy, logic [2:0] col);
        int bad = 0;
        if (base + 16 > q.size()) return 16;
        for (int i = 0; i < 16; i++) begin
            if (q[base+i].x !== 8'(cx*4 + i%4) || q[base+i].y !== 7'(cy*4 + i/4) ||
                q[base+i].c !== col || q[base+i].t !== q[base].t + i) bad++;
        end
        return bad;
    endfunction

    // Mismatches in a full 16x16 dead sweep starting at queue index base.
    function automatic int sweep_bad(int base);
        int bad = 0;
        if (base + 256 > q.size()) return 256;
        for (int i = 0; i < 256; i++) begin
            if (q[base+i].x !== 8'(i%16) || q[base+i].y !== 7'(i/16) ||
                q[base+i].c !== 3'b000 || q[base+i].t !== q[base].t + i) bad++;
        end
        return bad;
    endfunction

    task automatic push(input logic [7:0] cx, input logic [7:0] cy, input logic al,
                        output int k, output int w);
        logic ok;
        in_valid  = 1'b1;
        in_cell_x = cx;
        in_cell_y = cy;
        in_alive  = al;
        w = 0;
        k = -1;
        for (int n = 0; n < 100; n++) begin
            ok = in_ready;
            @(posedge clock);
            #1;
            if (ok === 1'b1) begin
                k = cyc;
                break;
            end
            w++;
        end
        in_valid = 1'b0;
        if (k < 0) begin
            checks++; errors++;
            $display("FAIL push_timeout: in_ready never high for (%0d,%0d)", cx, cy);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        logic ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if (busy === 1'b0 && plot === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b plot=%b after %0d cycles, required 0/0", name, busy, plot, budget);
        end
    endtask

    task automatic wait_plots(input int base, input int n, input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (q.size() - base >= n) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_plot_wait: got %0d plots, required %0d", name, q.size() - base, n);
        end
    endtask

    task automatic test_reset;
        int b, bad;
        repeat (2) @(negedge clock);
        checks++;
        if ({plot, in_ready, busy, dropped} !== 4'b0110) begin
            errors++;
            $display("FAIL reset_ctrl: plot/ready/busy/dropped=%b%b%b%b required 0110", plot, in_ready, busy, dropped);
        end
        checks++;
        if ({x, y, colour} !== 18'd0) begin
            errors++;
            $display("FAIL reset_pixel: x=%0d y=%0d colour=%0d required 0 0 0", x, y, colour);
        end
        b = q.size();
        @(posedge clock); #1;
        reset_n = 1'b1;
        wait_idle(400, "reset_clear");
        checks++;
        if (q.size() - b !== 256) begin
            errors++;
            $display("FAIL reset_clear_count: %0d plots, required 256", q.size() - b);
        end
        bad = sweep_bad(b);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_clear_sweep: %0d bad pixels, required 0", bad);
        end
        checks++;
        if (busy !== 1'b0 || plot !== 1'b0) begin
            errors++;
            $display("FAIL reset_clear_done: busy=%b plot=%b required 0 0", busy, plot);
        end
    endtask

    task automatic test_single;
        int b, k, w, bad;
        b = q.size();
        push(8'd1, 8'd2, 1'b1, k, w);
        wait_idle(100, "single");
        checks++;
        if (q.size() - b !== 16) begin
            errors++;
            $display("FAIL single_count: %0d plots, required 16", q.size() - b);
        end
        checks++;
        if (q.size() > b && q[b].t !== k + 2) begin
            errors++;
            $display("FAIL single_latency: first plot cycle %0d, required %0d", q[b].t, k + 2);
        end
        bad = cell_bad(b, 1, 2, 3'b111);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL single_block: %0d bad pixels, required 0", bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int b, k, w, stalls, bad, gaps;
        int cx[7] = '{0, 1, 2, 3, 0, 1, 2};
        int cy[7] = '{0, 0, 0, 0, 1, 1, 1};
        b = q.size();
        stalls = 0;
        push(8'd0, 8'd0, 1'b1, k, w);
        repeat (3) @(posedge clock);
        #1;
        for (int i = 1; i <= 4; i++) begin
            push(8'(cx[i]), 8'(cy[i]), 1'(i % 2 == 0), k, w);
            stalls += w;
        end
        checks++;
        if (stalls !== 0) begin
            errors++;
            $display("FAIL fill_first4_stalls: %0d stall cycles, required 0", stalls);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready_low: in_ready=%b with 4 queued, required 0", in_ready);
        end
        push(8'(cx[5]), 8'(cy[5]), 1'b0, k, w);
        checks++;
        if (w < 1) begin
            errors++;
            $display("FAIL fill_stall: 5th push stalled %0d cycles, required at least 1", w);
        end
        push(8'(cx[6]), 8'(cy[6]), 1'b1, k, w);
        wait_idle(400, "fill");
        checks++;
        if (q.size() - b !== 112) begin
            errors++;
            $display("FAIL fill_count: %0d plots, required 112", q.size() - b);
        end
        bad = 0;
        gaps = 0;
        for (int c = 0; c < 7; c++) begin
            bad += cell_bad(b + 16*c, cx[c], cy[c], (c % 2 == 0) ? 3'b111 : 3'b000);
            if (c < 6 && b + 16*(c+1) < q.size())
                if (q[b + 16*(c+1)].t - q[b + 16*c + 15].t !== 2) gaps++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL fill_order: %0d bad pixels, required 0", bad);
        end
        checks++;
        if (gaps !== 0) begin
            errors++;
            $display("FAIL fill_gap: %0d inter-cell gaps not exactly one idle cycle, required 0", gaps);
        end
    endtask

    task automatic test_out_of_range;
        int b, d0, k, w, bad;
        b = q.size();
        d0 = drop_cnt;
        push(8'd4, 8'd0, 1'b1, k, w);
        push(8'd0, 8'd0, 1'b0, k, w);
        wait_idle(100, "oor");
        checks++;
        if (drop_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL oor_dropped: %0d dropped pulses, required 1", drop_cnt - d0);
        end
        checks++;
        if (q.size() - b !== 16) begin
            errors++;
            $display("FAIL oor_count: %0d plots, required 16", q.size() - b);
        end
        bad = cell_bad(b, 0, 0, 3'b000);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL oor_block: %0d bad pixels, required 0", bad);
        end
    endtask

    task automatic test_clear_mid_paint;
        int b, k, w, bad;
        b = q.size();
        push(8'd3, 8'd3, 1'b1, k, w);
        wait_plots(b, 5, "clr");
        clear_req = 1'b1;
        push(8'd2, 8'd2, 1'b1, k, w);
        clear_req = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        clear_req = 1'b1;
        @(posedge clock); #1;
        clear_req = 1'b0;
        wait_idle(800, "clr");
        checks++;
        if (q.size() - b !== 288) begin
            errors++;
            $display("FAIL clr_count: %0d plots, required 288", q.size() - b);
        end
        bad = cell_bad(b, 3, 3, 3'b111);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL clr_cell_done: %0d bad pixels, required 0", bad);
        end
        bad = sweep_bad(b + 16);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL clr_sweep: %0d bad pixels, required 0", bad);
        end
        bad = cell_bad(b + 272, 2, 2, 3'b111);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL clr_queued_cell: %0d bad pixels, required 0", bad);
        end
    endtask

    task automatic test_reset_mid_paint;
        int b, k, w, bad;
        b = q.size();
        push(8'd1, 8'd1, 1'b1, k, w);
        push(8'd2, 8'd1, 1'b0, k, w);
        wait_plots(b, 7, "rst");
        reset_n = 1'b0;
        #1;
        checks++;
        if ({plot, in_ready, busy} !== 3'b011) begin
            errors++;
            $display("FAIL rst_async: plot/ready/busy=%b%b%b required 011", plot, in_ready, busy);
        end
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (plot !== 1'b0 || x !== 8'd0) begin
            errors++;
            $display("FAIL rst_held: plot=%b x=%0d required 0 0", plot, x);
        end
        b = q.size();
        reset_n = 1'b1;
        wait_idle(400, "rst");
        checks++;
        if (q.size() - b !== 256) begin
            errors++;
            $display("FAIL rst_count: %0d plots after release, required 256", q.size() - b);
        end
        bad = sweep_bad(b);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_sweep: %0d bad pixels, required 0", bad);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_out_of_range;
        test_clear_mid_paint;
        test_reset_mid_paint;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cell_plotter.md
# cell_plotter

Consumer end of the simulation→display path. Accepts changed-cell updates (cell coordinate plus new alive/dead state) from the Life simulation core through a valid/ready handshake and buffers them in a small FIFO. Expands each update into a CELL_PX×CELL_PX block of pixel writes, driving the x/y/colour/plot inputs of the 160x120 vga_adapter. After reset, and on request, it clears the grid area to the dead colour.

## Interface
- GRID_W, 4: grid width in cells.
- GRID_H, 4: grid height in cells.
- CELL_PX, 4: pixel side of one cell; power of two, 1..8.
- ORIGIN_X, 0 / ORIGIN_Y, 0: screen pixel of cell (0,0).
- FIFO_DEPTH, 4: update queue entries; power of two.
- ALIVE_COLOUR, 3'b111 / DEAD_COLOUR, 3'b000: RGB colours.
- clock  in  1  single clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  update present.
- in_ready  out  1  queue can accept; equals ~full.
- in_cell_x  in  8  cell column.
- in_cell_y  in  8  cell row.
- in_alive  in  1  new cell state.
- clear_req  in  1  single-cycle pulse; repaint the grid area dead.
- busy  out  1  high when state≠IDLE or the queue is non-empty.
- dropped  out  1  one-cycle pulse when an out-of-range update is discarded.
- x  out  8  pixel x to vga_adapter.
- y  out  7  pixel y to vga_adapter.
- colour  out  3  pixel colour.
- plot  out  1  write strobe.

## Operation
- FSM states: CLEAR, IDLE, PAINT. Reset state is CLEAR.
- **Push:** occurs when in_valid & in_ready. Entry {cell_x, cell_y, alive} is queued in every state, including CLEAR and PAINT.
- **CLEAR:** sweeps GRID_W·CELL_PX × GRID_H·CELL_PX pixels from (ORIGIN_X, ORIGIN_Y), row-major with x as the inner loop, one pixel per cycle, colour = DEAD_COLOUR. Goes to IDLE after the last pixel.
- **IDLE:** if a clear is pending (a clear_req seen outside CLEAR), go to CLEAR and drop the pending flag. Otherwise, if the queue is non-empty, pop one entry:
  - In range (cell_x < GRID_W and cell_y < GRID_H): latch the entry and go to PAINT.
  - Out of range: pulse dropped and stay in IDLE.
- **PAINT:** emits CELL_PX² pixels at x = ORIGIN_X + cell_x·CELL_PX + px and y = ORIGIN_Y + cell_y·CELL_PX + py, px inner. Colour is ALIVE_COLOUR if alive, else DEAD_COLOUR. Goes to IDLE after the last pixel.
- **clear_req handling:** in IDLE or PAINT it sets the pending flag, so a cell in progress always completes. In CLEAR it is ignored. Clearing never flushes the queue; queued updates are painted after the clear.
- **Arithmetic:** cell offsets are shifts by log2(CELL_PX). Pixel sums are 8 bits; y is truncated to 7 bits. An elaboration-time check requires the grid area to fit inside 160x120.
- **Ordering:** updates are painted in arrival order.

## Timing
- **Reset values:**
  - x=0, y=0, colour=0, plot=0, dropped=0.
  - Queue empty, in_ready=1, busy=1 (state CLEAR).
  - Pending clear flag = 0.
- All vga-side outputs and dropped are registered.
- **Handshake:** in_ready comes from the registered count, so a pop in the same cycle does not free a slot until the next cycle. When full, in_ready=0 even if a pop occurs that cycle.
- **Latency:**
  - Accept at edge k → entry visible to the FSM after edge k → pop at edge k+1 → first plot high in the cycle after edge k+2.
  - Each cell: CELL_PX² consecutive plot cycles, then ≥1 IDLE cycle with plot=0.
- **Clear duration:** GRID_W·GRID_H·CELL_PX² plot cycles (256 with defaults), with plot continuously high.
- **Reset assertion mid-operation:** plot drops immediately, the queue empties, the pending flag clears, and CLEAR restarts from the origin on reset release.

## Structure
- **Package life_pkg:** GRID_W, GRID_H, CELL_PX defaults, the colour constants, the plot_state_t enum {CLEAR, IDLE, PAINT}, and the cell_update_t struct {x[7:0], y[7:0], alive}. This package is shared with the simulation core.
- **Sub-module cell_fifo:** synchronous FIFO of cell_update_t with depth FIFO_DEPTH. Provides push/pop, registered count, full and empty.
- The top level holds the FSM, px/py counters, the address arithmetic and the output registers.

## Test plan
1. **Reset release, defaults:** exactly 256 plot cycles covering x 0..15, y 0..15, colour 000; then busy=0 and plot=0.
2. **Single update:** push (1,2,alive=1) at edge k → first plot in cycle k+2 at (4,8). Then 16 plots spanning x 4..7, y 8..11, colour 111; then busy=0.
3. **Queue fill:**
   - Push 6 updates back-to-back during one PAINT → in_ready falls once 4 entries are queued; later pushes stall until slots free.
   - All 6 are painted in order, with exactly one idle cycle between cells.
4. **Out-of-range update:** push (4,0) then (0,0,alive=0) → no pixel written for (4,0) and dropped pulses once. Then 16 plots at x 0..3, y 0..3, colour 000.
5. **clear_req mid-PAINT:** the current cell completes all 16 pixels, then a full 256-pixel clear runs, then the queued update is painted. A clear_req issued during CLEAR causes no second clear.
6. **Reset mid-PAINT:** assert reset_n=0 at pixel 7 → plot=0 and in_ready=1 during reset. On release, the clear restarts at (0,0) and no previously queued update is painted.
